// File: rtl/seq_alu_pkg.sv
// Shared op/state encodings for seq_alu. The MUL opcode is legal only when
// SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_comb.sv
// Single-cycle AND/OR/ADD/SUB/SLT result and signed overflow; unknown ops give 0.
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;

  // SUB reuses the adder as a + ~b + 1
  assign sub   = (op == OP_SUB);
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD, OP_SUB: begin
        res = sum;
        ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: IDLE -> (BUSY) -> DONE with registered result and flags.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier (op 011).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             ovf,
  output logic             ill
);

  if (WIDTH < 4 || WIDTH > 64 || (64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_width
    $error("seq_alu: WIDTH out of range");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_res;
  logic             c_ovf;
  logic             legal;
  logic             start_mul;
  logic             mul_last;
  logic             accept;

  seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (a),
    .b   (b),
    .op  (op),
    .res (c_res),
    .ovf (c_ovf)
  );

  assign legal     = op_legal(op);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_ready && in_valid;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  assign start_mul = (op == OP_MUL);
  // mcand is pre-shifted each step, so it always equals a << (WIDTH-cnt)
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept && start_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= CNT_W'(WIDTH);
    end else if (state_q == ST_BUSY) begin
      mcand  <= mcand << 1;
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end
`else
  assign start_mul = 1'b0;
  assign mul_last  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = start_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_last) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result/flags only change on entry to DONE, so they hold while it waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z    <= '0;
      zero <= 1'b0;
      ovf  <= 1'b0;
      ill  <= 1'b0;
    end else if (accept && !start_mul) begin
      z    <= legal ? c_res : '0;
      zero <= !legal || (c_res == '0);
      ovf  <= legal && c_ovf;
      ill  <= !legal;
    end
`ifdef SEQ_ALU_MUL_EN
    else if (state_q == ST_BUSY && mul_last) begin
      z    <= acc_nxt[WIDTH-1:0];
      zero <= (acc_nxt[WIDTH-1:0] == '0);
      ovf  <= |acc_nxt[2*WIDTH-1:WIDTH];
      ill  <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed plan plus random ops
// checked against an arithmetic reference model.
module tb_seq_alu;

`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        zero, ovf, ill;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zero      (zero),
    .ovf       (ovf),
    .ill       (ill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain signed/unsigned integer arithmetic
  function automatic void model(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                output logic [31:0] ez, output bit eovf, output bit eill,
                                output int lat);
    longint sa, sb, s;
    longint unsigned p;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ez = '0; eovf = 1'b0; eill = 1'b0; lat = 1;
    case (o)
      3'b000: ez = xa & xb;
      3'b001: ez = xa | xb;
      3'b010: begin s = sa + sb; ez = s[31:0]; eovf = (s > SMAX) || (s < SMIN); end
      3'b110: begin s = sa - sb; ez = s[31:0]; eovf = (s > SMAX) || (s < SMIN); end
      3'b111: ez = (sa < sb) ? 32'd1 : 32'd0;
      3'b011: begin
        if (MUL_EN) begin
          p    = {32'h0, xa} * {32'h0, xb};
          ez   = p[31:0];
          eovf = (p >> 32) != 0;
          lat  = 33;
        end else eill = 1'b1;
      end
      default: eill = 1'b1;
    endcase
  endfunction

  // Starts and ends on a negedge; stall>0 holds out_ready low with junk on the input.
  task automatic do_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input bit hold_rdy, input int stall, input string tag);
    logic [31:0] ez;
    bit eovf, eill;
    int lat, cyc;
    model(o, xa, xb, ez, eovf, eill, lat);
    check({tag, "/in_ready"}, in_ready, 1);
    out_ready = hold_rdy;
    in_valid  = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, cyc, lat);
    check({tag, "/z"}, z, ez);
    check({tag, "/zero"}, zero, (ez == 0));
    check({tag, "/ovf"}, ovf, eovf);
    check({tag, "/ill"}, ill, eill);
    check({tag, "/busy_ready"}, in_ready, 0);
    if (!hold_rdy) begin
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
        @(negedge clk);
        check({tag, "/hold_valid"}, out_valid, 1);
        check({tag, "/hold_z"}, {z, zero, ovf, ill}, {ez, (ez == 0), eovf, eill});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    check({tag, "/released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] corner [6];
    int stale;
    corner = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset/outs", {out_valid, z, zero, ovf, ill}, '0);
    check("reset/in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'b010, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0, 0, "add");
    do_op(3'b110, 32'h8000_0000, 32'h0000_0001, 1'b0, 0, "sub_wrap");
    do_op(3'b110, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 0, "sub_eq");
    do_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "slt");
    do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 0, "and");
    do_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 0, "or");
    do_op(3'b011, 32'h0001_0000, 32'h0001_0000, 1'b0, 0, "mul_big");
    do_op(3'b011, 32'd7, 32'd6, 1'b0, 0, "mul_small");
    do_op(3'b100, 32'h1111_1111, 32'h2222_2222, 1'b0, 0, "ill100");
    do_op(3'b101, 32'h1111_1111, 32'h2222_2222, 1'b0, 0, "ill101");
    do_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5, "backpressure");
    // out_ready held high: DONE still lasts a cycle, next op accepted right after
    do_op(3'b010, 32'd100, 32'd23, 1'b1, 0, "b2b_0");
    do_op(3'b110, 32'd100, 32'd23, 1'b1, 0, "b2b_1");

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      do_op(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand");
    end

    // Reset ten cycles into an operation: nothing may survive it
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b011; a = 32'd7; b = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset/outs", {out_valid, z, zero, ovf, ill}, '0);
    check("midreset/in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midreset/stale", stale, 0);
    check("midreset/idle", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
